hmac_request_arbiter: RTL and testbench

Shares a single `hmac_controller` (and the `keccak_top` sponge behind it) between one PUF key-enrollment requester and `NUM_REQ` MAC requesters.
- Arbitrates between the requesters and issues the controller's start pulses.
- Muxes the owning requester's 32-bit message stream onto the controller.
- Returns the 512-bit tag to that owner.
- Sits between the per-client message sources and the controller. It is the only block allowed to drive `start_puf`, `start_hmac` and the `msg_*` inputs of the controller.

---
 rtl/hmac_request_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_hmac_request_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hmac_request_arbiter.sv
// rtl/hmac_request_arbiter.sv - shares one hmac_controller between a PUF enroller and NUM_REQ MAC requesters
// Optional feature: define HMAC_ARB_RR_EN for round-robin MAC arbitration (default: fixed priority, lowest index wins).
module hmac_request_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   puf_req,
  input  logic [NUM_REQ-1:0]     mac_req,
  input  logic [32*NUM_REQ-1:0]  req_msg_word,
  input  logic [NUM_REQ-1:0]     req_msg_valid,
  input  logic [NUM_REQ-1:0]     req_msg_last,
  output logic [NUM_REQ-1:0]     req_msg_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     mac_done,
  output logic                   puf_done,
  output logic [511:0]           tag,
  output logic                   key_valid,
  output logic                   proto_err,
  output logic                   ctl_start_puf,
  output logic                   ctl_start_hmac,
  output logic [31:0]            ctl_msg_word,
  output logic                   ctl_msg_valid,
  output logic                   ctl_msg_last,
  input  logic                   ctl_msg_ready,
  input  logic                   ctl_done,
  input  logic [511:0]           ctl_hmac_out
);

  // Two index bits cover the legal 1..4 requesters.
  localparam int IDX_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUF_START,
    S_PUF_WAIT,
    S_MAC_START,
    S_MAC_STREAM,
    S_MAC_WAIT,
    S_RELEASE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [511:0]       tag_q, tag_d;
  logic               key_valid_q, key_valid_d;
  logic               puf_done_q, puf_done_d;
  logic               proto_err_q, proto_err_d;

  logic [NUM_REQ-1:0] owner_oh;
  logic [31:0]        own_word;
  logic               own_valid;
  logic               own_last;
  logic               in_stream;
  logic               owns_grant;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   low_idx;

`ifdef HMAC_ARB_RR_EN
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   high_idx;
  logic               high_found;
`endif

  // Decode the registered owner index into a one-hot vector.
  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) owner_oh[i] = 1'b1;
    end
  end

  // Select the owner's stream; non-owners are never looked at.
  always_comb begin
    own_word  = '0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_oh[i]) begin
        own_word  = req_msg_word[32*i +: 32];
        own_valid = req_msg_valid[i];
        own_last  = req_msg_last[i];
      end
    end
  end

  // Lowest-index requester; the fixed-priority winner and the round-robin wrap fallback.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (mac_req[i]) low_idx = IDX_W'(i);
    end
  end

`ifdef HMAC_ARB_RR_EN
  // First requester at or above the pointer; if none, wrap to the lowest one.
  always_comb begin
    high_idx   = '0;
    high_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (mac_req[i] && (IDX_W'(i) >= rr_ptr_q)) begin
        high_idx   = IDX_W'(i);
        high_found = 1'b1;
      end
    end
    win_idx = high_found ? high_idx : low_idx;
  end
`else
  assign win_idx = low_idx;
`endif

  // Next-state logic; control outputs are decoded from state below so nothing here reaches them combinationally.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    tag_d       = tag_q;
    key_valid_d = key_valid_q;
    puf_done_d  = 1'b0;
    proto_err_d = proto_err_q;
`ifdef HMAC_ARB_RR_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (puf_req) begin
          state_d = S_PUF_START;
        end else if (key_valid_q && (|mac_req)) begin
          state_d = S_MAC_START;
          owner_d = win_idx;
        end
      end
      S_PUF_START: state_d = S_PUF_WAIT;
      S_PUF_WAIT: begin
        if (ctl_done) begin
          key_valid_d = 1'b1;
          puf_done_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_MAC_START: state_d = S_MAC_STREAM;
      S_MAC_STREAM: begin
        if (own_valid && ctl_msg_ready && own_last) state_d = S_MAC_WAIT;
      end
      S_MAC_WAIT: begin
        if (ctl_done) begin
          tag_d   = ctl_hmac_out;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
`ifdef HMAC_ARB_RR_EN
        if (owner_q == IDX_W'(NUM_REQ - 1)) rr_ptr_d = '0;
        else                                 rr_ptr_d = owner_q + IDX_W'(1);
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A completion the controller should not be producing right now.
    if (ctl_done && (state_q != S_PUF_WAIT) && (state_q != S_MAC_WAIT)) proto_err_d = 1'b1;
  end

  // State and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      tag_q       <= '0;
      key_valid_q <= 1'b0;
      puf_done_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      tag_q       <= tag_d;
      key_valid_q <= key_valid_d;
      puf_done_q  <= puf_done_d;
      proto_err_q <= proto_err_d;
    end
  end

`ifdef HMAC_ARB_RR_EN
  // Round-robin pointer; moves only when a MAC transaction is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rr_ptr_q <= '0;
    else          rr_ptr_q <= rr_ptr_d;
  end
`endif

  assign in_stream  = (state_q == S_MAC_STREAM);
  assign owns_grant = (state_q == S_MAC_START) || (state_q == S_MAC_STREAM) ||
                      (state_q == S_MAC_WAIT)  || (state_q == S_RELEASE);

  assign grant          = owns_grant ? owner_oh : '0;
  assign mac_done       = (state_q == S_RELEASE) ? owner_oh : '0;
  assign ctl_start_puf  = (state_q == S_PUF_START);
  assign ctl_start_hmac = (state_q == S_MAC_START);
  assign puf_done       = puf_done_q;
  assign key_valid      = key_valid_q;
  assign proto_err      = proto_err_q;
  assign tag            = tag_q;

  assign ctl_msg_word   = in_stream ? own_word : 32'h0;
  assign ctl_msg_valid  = in_stream && own_valid;
  assign ctl_msg_last   = in_stream && own_last;
  assign req_msg_ready  = (in_stream && ctl_msg_ready) ? owner_oh : '0;

endmodule

// File: tb/tb_hmac_request_arbiter.sv
// tb/tb_hmac_request_arbiter.sv - directed self-checking bench for hmac_request_arbiter
module tb_hmac_request_arbiter;

  localparam int N = 2;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           puf_req;
  logic [N-1:0]   mac_req;
  logic [32*N-1:0] req_msg_word;
  logic [N-1:0]   req_msg_valid;
  logic [N-1:0]   req_msg_last;
  logic [N-1:0]   req_msg_ready;
  logic [N-1:0]   grant;
  logic [N-1:0]   mac_done;
  logic           puf_done;
  logic [511:0]   tag;
  logic           key_valid;
  logic           proto_err;
  logic           ctl_start_puf;
  logic           ctl_start_hmac;
  logic [31:0]    ctl_msg_word;
  logic           ctl_msg_valid;
  logic           ctl_msg_last;
  logic           ctl_msg_ready;
  logic           ctl_done;
  logic [511:0]   ctl_hmac_out;

  int checks = 0;
  int errors = 0;

  logic [511:0] pat_a5;
  logic [511:0] pat_3c;
  logic [N-1:0] exp_second;
  logic [31:0]  exp_second_word;

  hmac_request_arbiter #(.NUM_REQ(N)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .puf_req        (puf_req),
    .mac_req        (mac_req),
    .req_msg_word   (req_msg_word),
    .req_msg_valid  (req_msg_valid),
    .req_msg_last   (req_msg_last),
    .req_msg_ready  (req_msg_ready),
    .grant          (grant),
    .mac_done       (mac_done),
    .puf_done       (puf_done),
    .tag            (tag),
    .key_valid      (key_valid),
    .proto_err      (proto_err),
    .ctl_start_puf  (ctl_start_puf),
    .ctl_start_hmac (ctl_start_hmac),
    .ctl_msg_word   (ctl_msg_word),
    .ctl_msg_valid  (ctl_msg_valid),
    .ctl_msg_last   (ctl_msg_last),
    .ctl_msg_ready  (ctl_msg_ready),
    .ctl_done       (ctl_done),
    .ctl_hmac_out   (ctl_hmac_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    puf_req       = 1'b0;
    mac_req       = '0;
    req_msg_word  = '0;
    req_msg_valid = '0;
    req_msg_last  = '0;
    ctl_msg_ready = 1'b0;
    ctl_done      = 1'b0;
    ctl_hmac_out  = '0;
    pat_a5        = {64{8'hA5}};
    pat_3c        = {64{8'h3C}};
`ifdef HMAC_ARB_RR_EN
    exp_second      = 2'b10;
    exp_second_word = 32'hBBBB_0001;
`else
    exp_second      = 2'b01;
    exp_second_word = 32'hAAAA_0001;
`endif

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_grant", grant, 2'b00);
    chk("rst_tag", tag, 512'h0);
    chk("rst_key_valid", key_valid, 1'b0);
    chk("rst_proto_err", proto_err, 1'b0);
    chk("rst_starts", {ctl_start_puf, ctl_start_hmac}, 2'b00);
    chk("rst_dones", {puf_done, mac_done}, 3'b000);
    chk("rst_ready", req_msg_ready, 2'b00);
    reset_n = 1'b1;
    mac_req = 2'b01;

    // MAC held off without a key
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("holdoff_grant", grant, 2'b00);
      chk("holdoff_start", ctl_start_hmac, 1'b0);
    end

    // PUF enrollment
    puf_req = 1'b1;
    @(negedge clk);
    chk("puf_start", ctl_start_puf, 1'b1);
    chk("puf_start_grant", grant, 2'b00);
    puf_req = 1'b0;
    @(negedge clk);
    chk("puf_wait_start", ctl_start_puf, 1'b0);
    chk("puf_wait_done", puf_done, 1'b0);
    ctl_done = 1'b1;
    @(negedge clk);
    ctl_done = 1'b0;
    chk("puf_done_pulse", puf_done, 1'b1);
    chk("key_valid_set", key_valid, 1'b1);
    chk("puf_idle_grant", grant, 2'b00);
    chk("puf_no_proto_err", proto_err, 1'b0);

    // Single 3-word MAC for requester 0; requester 1 pushes junk
    @(negedge clk);
    chk("mac_start_grant", grant, 2'b01);
    chk("mac_start_pulse", ctl_start_hmac, 1'b1);
    chk("puf_done_one_cycle", puf_done, 1'b0);
    mac_req       = 2'b00;
    req_msg_word  = {32'hDEAD_BEEF, 32'h1111_0001};
    req_msg_valid = 2'b11;
    req_msg_last  = 2'b10;
    ctl_msg_ready = 1'b0;
    #1;
    chk("start_no_fwd", ctl_msg_valid, 1'b0);
    chk("start_no_ready", req_msg_ready, 2'b00);
    @(negedge clk);
    chk("stream_start_low", ctl_start_hmac, 1'b0);
    chk("stall_ready", req_msg_ready, 2'b00);
    chk("beat1_valid", ctl_msg_valid, 1'b1);
    chk("beat1_word", ctl_msg_word, 32'h1111_0001);
    chk("beat1_last", ctl_msg_last, 1'b0);
    ctl_msg_ready = 1'b1;
    #1;
    chk("beat1_ready", req_msg_ready, 2'b01);
    @(negedge clk);
    req_msg_word[31:0] = 32'h1111_0002;
    ctl_done = 1'b1;
    #1;
    chk("beat2_word", ctl_msg_word, 32'h1111_0002);
    @(negedge clk);
    ctl_done = 1'b0;
    chk("spurious_proto_err", proto_err, 1'b1);
    chk("spurious_grant", grant, 2'b01);
    chk("spurious_stream", ctl_msg_valid, 1'b1);
    req_msg_word[31:0] = 32'h1111_0003;
    req_msg_last = 2'b11;
    #1;
    chk("beat3_word", ctl_msg_word, 32'h1111_0003);
    chk("beat3_last", ctl_msg_last, 1'b1);
    @(negedge clk);
    chk("wait_valid", ctl_msg_valid, 1'b0);
    chk("wait_ready", req_msg_ready, 2'b00);
    chk("wait_word", ctl_msg_word, 32'h0);
    chk("wait_grant", grant, 2'b01);
    chk("wait_mac_done", mac_done, 2'b00);
    req_msg_valid = 2'b00;
    req_msg_last  = 2'b00;
    ctl_hmac_out  = pat_a5;
    ctl_done      = 1'b1;
    @(negedge clk);
    ctl_done = 1'b0;
    chk("release_mac_done", mac_done, 2'b01);
    chk("release_tag", tag, pat_a5);
    chk("release_grant", grant, 2'b01);
    chk("proto_err_sticky", proto_err, 1'b1);
    ctl_hmac_out = '0;
    @(negedge clk);
    chk("idle_mac_done", mac_done, 2'b00);
    chk("idle_grant", grant, 2'b00);
    chk("tag_held", tag, pat_a5);

    // Asynchronous reset in the middle of a stream
    mac_req = 2'b10;
    @(negedge clk);
    chk("r1_grant", grant, 2'b10);
    @(negedge clk);
    req_msg_word  = {32'h2222_0001, 32'h0};
    req_msg_valid = 2'b10;
    ctl_msg_ready = 1'b1;
    #1;
    chk("r1_word", ctl_msg_word, 32'h2222_0001);
    chk("r1_ready", req_msg_ready, 2'b10);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_grant", grant, 2'b00);
    chk("async_rst_tag", tag, 512'h0);
    chk("async_rst_key_valid", key_valid, 1'b0);
    chk("async_rst_proto_err", proto_err, 1'b0);
    chk("async_rst_valid", ctl_msg_valid, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    req_msg_valid = 2'b00;
    @(negedge clk);
    chk("post_rst_grant", grant, 2'b00);
    chk("post_rst_starts", {ctl_start_puf, ctl_start_hmac}, 2'b00);

    // Simultaneous PUF and MAC requests, then two contending MACs
    puf_req = 1'b1;
    mac_req = 2'b11;
    @(negedge clk);
    chk("simul_puf_start", ctl_start_puf, 1'b1);
    chk("simul_no_grant", grant, 2'b00);
    puf_req = 1'b0;
    @(negedge clk);
    ctl_done = 1'b1;
    @(negedge clk);
    ctl_done = 1'b0;
    chk("simul_puf_done", puf_done, 1'b1);
    chk("simul_idle_grant", grant, 2'b00);
    @(negedge clk);
    chk("first_grant", grant, 2'b01);
    chk("first_start", ctl_start_hmac, 1'b1);
    req_msg_word  = {32'hBBBB_0001, 32'hAAAA_0001};
    req_msg_valid = 2'b11;
    req_msg_last  = 2'b11;
    ctl_msg_ready = 1'b1;
    @(negedge clk);
    chk("first_word", ctl_msg_word, 32'hAAAA_0001);
    chk("first_last", ctl_msg_last, 1'b1);
    @(negedge clk);
    req_msg_valid = 2'b00;
    ctl_hmac_out  = pat_3c;
    ctl_done      = 1'b1;
    @(negedge clk);
    ctl_done = 1'b0;
    chk("first_mac_done", mac_done, 2'b01);
    chk("first_tag", tag, pat_3c);
    @(negedge clk);
    chk("gap_grant", grant, 2'b00);
    chk("gap_start", ctl_start_hmac, 1'b0);
    @(negedge clk);
    chk("second_grant", grant, exp_second);
    chk("second_start", ctl_start_hmac, 1'b1);
    req_msg_valid = 2'b11;
    @(negedge clk);
    chk("second_word", ctl_msg_word, exp_second_word);
    @(negedge clk);
    req_msg_valid = 2'b00;
    ctl_hmac_out  = pat_a5;
    ctl_done      = 1'b1;
    @(negedge clk);
    ctl_done = 1'b0;
    chk("second_mac_done", mac_done, exp_second);
    chk("second_tag", tag, pat_a5);
    chk("final_proto_err", proto_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
